// File: rtl/prog_counter_pkg.sv
// Shared mode encodings and terminal-value helpers for the programmable counter.
package prog_counter_pkg;

    // Widest counter the helper functions can describe.
    localparam int unsigned MaxWidth = 32;

    localparam logic [1:0] MODE_FREE    = 2'b00;
    localparam logic [1:0] MODE_MOD     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ModeFree    = MODE_FREE,
        ModeMod     = MODE_MOD,
        ModeOneshot = MODE_ONESHOT,
        ModeRsvd    = 2'b11
    } mode_e;

    // The reserved encoding behaves exactly like free-run.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            MODE_MOD:     m = ModeMod;
            MODE_ONESHOT: m = ModeOneshot;
            default:      m = ModeFree;
        endcase
        return m;
    endfunction

    function automatic logic [MaxWidth-1:0] all_ones(input int unsigned width);
        logic [MaxWidth-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Value at which the counter wraps, holds or finishes.
    function automatic logic [MaxWidth-1:0] term_val(input mode_e               mode,
                                                     input logic                dir,
                                                     input logic [MaxWidth-1:0] mod_val,
                                                     input int unsigned         width);
        logic [MaxWidth-1:0] t;
        if (!dir) begin
            t = '0;
        end else if (mode == ModeFree) begin
            t = all_ones(width);
        end else begin
            t = mod_val;
        end
        return t;
    endfunction

endpackage

// File: rtl/prog_counter_prescaler.sv
// Enable-gated clock prescaler: one tick every prescale+1 enabled cycles.
module prog_counter_prescaler #(
    parameter int unsigned PSC_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PSC_W-1:0] prescale_i,
    output logic             tick_o
);

    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;

    // >= rather than == so lowering prescale below the running count ticks at once.
    assign tick_o = en_i && (psc_cnt_q >= prescale_i);

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (clr_i) begin
            psc_cnt_d = '0;
        end else if (en_i) begin
            psc_cnt_d = tick_o ? '0 : psc_cnt_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Loadable WIDTH-bit up/down counter with free-run, modulo and one-shot modes,
// prescaled stepping, terminal-count pulse and a replicated pad output-enable.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      PSC_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] mod_val_i,
    input  logic [PSC_W-1:0] prescale_i,
    input  logic             oe_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_oe_o,
    output logic             tc_o,
    output logic             done_o
);

    logic [WIDTH-1:0]    count_q, count_d;
    logic                tc_q, tc_d;
    logic                done_q, done_d;
    logic                tick;
    mode_e               mode;
    logic [MaxWidth-1:0] mod_ext;
    logic [MaxWidth-1:0] term_full;
    logic [WIDTH-1:0]    term;

    prog_counter_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .clr_i      (load_i),
        .prescale_i (prescale_i),
        .tick_o     (tick)
    );

    always_comb begin
        mod_ext             = '0;
        mod_ext[WIDTH-1:0]  = mod_val_i;
        mode                = decode_mode(mode_i);
        term_full           = term_val(mode, dir_i, mod_ext, WIDTH);
        term                = term_full[WIDTH-1:0];
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (load_i) begin
            count_d = load_val_i;
            done_d  = 1'b0;
        end else if (tick && !done_q) begin
            if (count_q == term) begin
                case (mode)
                    ModeMod: begin
                        count_d = dir_i ? '0 : mod_val_i;
                        tc_d    = 1'b1;
                    end
                    ModeOneshot: begin
                        // Hold at the terminal value; done_q gates any later pulse.
                        done_d = 1'b1;
                        tc_d   = 1'b1;
                    end
                    default: begin
                        count_d = dir_i ? '0 : '1;
                        tc_d    = 1'b1;
                    end
                endcase
            end else begin
                count_d = dir_i ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count_o    = count_q;
    assign tc_o       = tc_q;
    assign done_o     = done_q;
    assign count_oe_o = {WIDTH{oe_i}};

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: directed vectors push expectations, a monitor checks them.
module tb_prog_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en, load, dir, oe;
    logic [7:0] load_val, mod_val;
    logic [1:0] mode;
    logic [3:0] prescale;
    logic [7:0] count, count_oe;
    logic       tc, done;

    logic        en2, load2, oe2;
    logic [11:0] load_val2, count2, count_oe2;
    logic [1:0]  prescale2;
    logic        tc2, done2;

    prog_counter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .load_i     (load),
        .load_val_i (load_val),
        .dir_i      (dir),
        .mode_i     (mode),
        .mod_val_i  (mod_val),
        .prescale_i (prescale),
        .oe_i       (oe),
        .count_o    (count),
        .count_oe_o (count_oe),
        .tc_o       (tc),
        .done_o     (done)
    );

    prog_counter #(
        .WIDTH   (12),
        .PSC_W   (2),
        .RST_VAL (12'h123)
    ) dut2 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en2),
        .load_i     (load2),
        .load_val_i (load_val2),
        .dir_i      (1'b1),
        .mode_i     (2'b00),
        .mod_val_i  (12'h000),
        .prescale_i (prescale2),
        .oe_i       (oe2),
        .count_o    (count2),
        .count_oe_o (count_oe2),
        .tc_o       (tc2),
        .done_o     (done2)
    );

    typedef struct {
        int unsigned cyc;
        int unsigned tag;
        logic [7:0]  count;
        logic        tc;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned tag_n = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expect (c, t, d) on the outputs after the next rising edge.
    task automatic step(input logic [7:0] c, input logic t, input logic d);
        exp_t e;
        e.cyc   = cyc + 1;
        e.tag   = tag_n;
        e.count = c;
        e.tc    = t;
        e.done  = d;
        tag_n++;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic holds(input int n, input logic [7:0] c, input logic d);
        repeat (n) step(c, 1'b0, d);
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) begin
                check($sformatf("stale#%0d", mon_e.tag), cyc, mon_e.cyc);
            end else begin
                check($sformatf("count#%0d", mon_e.tag), {24'd0, count}, {24'd0, mon_e.count});
                check($sformatf("tc#%0d", mon_e.tag), {31'd0, tc}, {31'd0, mon_e.tc});
                check($sformatf("done#%0d", mon_e.tag), {31'd0, done}, {31'd0, mon_e.done});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; en = 1'b1; load = 1'b0; load_val = 8'h00; dir = 1'b1; oe = 1'b0;
        mode = 2'b00; mod_val = 8'h00; prescale = 4'd0;
        en2 = 1'b0; load2 = 1'b0; load_val2 = 12'h000; prescale2 = 2'd1; oe2 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", {24'd0, count}, 32'h00);
        check("rst_tc", {31'd0, tc}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count_w12", {20'd0, count2}, 32'h123);
        @(negedge clk); #2 rst_n = 1'b1;

        // Count up to 0x37, then reset asynchronously mid-cycle.
        load = 1'b1; load_val = 8'h30; step(8'h30, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 1; i <= 7; i++) step(8'(8'h30 + i), 1'b0, 1'b0);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        check("async_rst_count", {24'd0, count}, 32'h00);
        check("async_rst_tc", {31'd0, tc}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        #1 rst_n = 1'b1;

        // Free-run up wrap.
        load = 1'b1; load_val = 8'hFE; step(8'hFE, 1'b0, 1'b0);
        load = 1'b0;
        step(8'hFF, 1'b0, 1'b0); step(8'h00, 1'b1, 1'b0); step(8'h01, 1'b0, 1'b0);

        // Free-run down wrap.
        dir = 1'b0; load = 1'b1; load_val = 8'h01; step(8'h01, 1'b0, 1'b0);
        load = 1'b0;
        step(8'h00, 1'b0, 1'b0); step(8'hFF, 1'b1, 1'b0); step(8'hFE, 1'b0, 1'b0);

        // Mode 11 behaves as free-run, ignoring mod_val.
        dir = 1'b1; mode = 2'b11; mod_val = 8'd5;
        load = 1'b1; load_val = 8'hFE; step(8'hFE, 1'b0, 1'b0);
        load = 1'b0;
        step(8'hFF, 1'b0, 1'b0); step(8'h00, 1'b1, 1'b0);

        // Modulo 9 with prescale 2, then reverse at 3.
        mode = 2'b01; mod_val = 8'd9; prescale = 4'd2;
        load = 1'b1; load_val = 8'd0; step(8'd0, 1'b0, 1'b0);
        load = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            holds(2, 8'(v - 1), 1'b0); step(8'(v), 1'b0, 1'b0);
        end
        holds(2, 8'd9, 1'b0); step(8'd0, 1'b1, 1'b0);
        for (int v = 1; v <= 3; v++) begin
            holds(2, 8'(v - 1), 1'b0); step(8'(v), 1'b0, 1'b0);
        end
        dir = 1'b0;
        holds(2, 8'd3, 1'b0); step(8'd2, 1'b0, 1'b0);
        holds(2, 8'd2, 1'b0); step(8'd1, 1'b0, 1'b0);
        holds(2, 8'd1, 1'b0); step(8'd0, 1'b0, 1'b0);
        holds(2, 8'd0, 1'b0); step(8'd9, 1'b1, 1'b0);
        step(8'd9, 1'b0, 1'b0);

        // Modulo up above mod_val runs through 0 without a pulse.
        dir = 1'b1; prescale = 4'd0;
        load = 1'b1; load_val = 8'hFE; step(8'hFE, 1'b0, 1'b0);
        load = 1'b0;
        step(8'hFF, 1'b0, 1'b0); step(8'h00, 1'b0, 1'b0); step(8'h01, 1'b0, 1'b0);

        // mod_val 0: stays at 0, pulse every tick.
        mod_val = 8'd0;
        load = 1'b1; load_val = 8'd0; step(8'd0, 1'b0, 1'b0);
        load = 1'b0;
        step(8'd0, 1'b1, 1'b0); step(8'd0, 1'b1, 1'b0);

        // One-shot to 5, sticky through dir/mode changes, released by load.
        mode = 2'b10; mod_val = 8'd5;
        load = 1'b1; load_val = 8'd0; step(8'd0, 1'b0, 1'b0);
        load = 1'b0;
        for (int v = 1; v <= 5; v++) step(8'(v), 1'b0, 1'b0);
        step(8'd5, 1'b1, 1'b1);
        holds(10, 8'd5, 1'b1);
        dir = 1'b0; mode = 2'b00;
        holds(10, 8'd5, 1'b1);
        dir = 1'b1; mode = 2'b10;
        load = 1'b1; load_val = 8'd2; step(8'd2, 1'b0, 1'b0);
        load = 1'b0;
        step(8'd3, 1'b0, 1'b0); step(8'd4, 1'b0, 1'b0); step(8'd5, 1'b0, 1'b0);
        step(8'd5, 1'b1, 1'b1); step(8'd5, 1'b0, 1'b1);

        // Load on a tick edge restarts the prescaler; en=0 freezes everything.
        mode = 2'b00; prescale = 4'd3;
        load = 1'b1; load_val = 8'h10; step(8'h10, 1'b0, 1'b0);
        load = 1'b0;
        holds(3, 8'h10, 1'b0); step(8'h11, 1'b0, 1'b0);
        holds(3, 8'h11, 1'b0);
        load = 1'b1; load_val = 8'h40; step(8'h40, 1'b0, 1'b0);
        load = 1'b0;
        holds(2, 8'h40, 1'b0);
        en = 1'b0;
        holds(10, 8'h40, 1'b0);
        en = 1'b1;
        step(8'h40, 1'b0, 1'b0); step(8'h41, 1'b0, 1'b0);
        en = 1'b0; load = 1'b1; load_val = 8'h80; step(8'h80, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;

        // Output enable replicate.
        check("count_oe_off", {24'd0, count_oe}, 32'h00);
        oe = 1'b1; #1;
        check("count_oe_on", {24'd0, count_oe}, 32'hFF);
        step(8'h80, 1'b0, 1'b0);
        oe = 1'b0; #1;
        check("count_oe_off2", {24'd0, count_oe}, 32'h00);
        step(8'h80, 1'b0, 1'b0);

        // 12-bit / 2-bit-prescaler build.
        check("hold_count_w12", {20'd0, count2}, 32'h123);
        oe2 = 1'b1; #1;
        check("count_oe_w12", {20'd0, count_oe2}, 32'hFFF);
        en2 = 1'b1; load2 = 1'b1; load_val2 = 12'hFFE;
        @(posedge clk); #1;
        check("load_w12", {20'd0, count2}, 32'hFFE);
        load2 = 1'b0;
        @(posedge clk); #1;
        check("psc_hold_w12", {20'd0, count2}, 32'hFFE);
        @(posedge clk); #1;
        check("step_w12", {20'd0, count2}, 32'hFFF);
        @(posedge clk); #1;
        check("psc_hold2_w12", {20'd0, count2}, 32'hFFF);
        @(posedge clk); #1;
        check("wrap_w12", {20'd0, count2}, 32'h000);
        check("wrap_tc_w12", {31'd0, tc2}, 32'd1);
        @(posedge clk); #1;
        check("tc_clear_w12", {31'd0, tc2}, 32'd0);
        check("done_w12", {31'd0, done2}, 32'd0);

        @(negedge clk); @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
